// File: rtl/scv_pkg.sv
// rtl/scv_pkg.sv - shared constants and word type for the cartridge loader
package scv_pkg;

  localparam int         CART_ADDR_W = 17;
  localparam logic [7:0] CART_IDX    = 8'h01;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } cart_word_t;

  function automatic logic [7:0] word_byte(input cart_word_t w, input logic hi);
    return hi ? w.data[15:8] : w.data[7:0];
  endfunction

endpackage

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - host download words to byte-wide ROM store init stream
module cart_loader
  import scv_pkg::*;
#(
  parameter logic [7:0] CART_INDEX = CART_IDX,
  parameter int         HDR_BYTES  = 0,
  parameter int         ADDR_W     = CART_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IOCTL_DOWNLOAD,
  input  logic [7:0]        IOCTL_INDEX,
  input  logic              IOCTL_WR,
  input  logic [24:0]       IOCTL_ADDR,
  input  logic [15:0]       IOCTL_DOUT,
  output logic              IOCTL_WAIT,
  output logic              INIT_SEL,
  output logic [ADDR_W-1:0] INIT_ADDR,
  output logic [7:0]        INIT_DATA,
  output logic              INIT_VALID,
  output logic              OVERSIZE
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  localparam logic [24:0] HDR = 25'(HDR_BYTES);

  state_t      state, state_next;
  cart_word_t  in_word;
  cart_word_t  h_word, h_word_next, s_word, s_word_next;
  logic        h_valid, h_valid_next, s_valid, s_valid_next;
  logic        h_phase, h_phase_next;
  logic        sel_match, accept, h_release;
  logic [24:0] byte_addr, rel_addr;
  logic        in_header, over, emit;
  logic [7:0]  cur_byte;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]  data_q;
  logic        init_sel_q, oversize_q;

  assign sel_match = IOCTL_DOWNLOAD & (IOCTL_INDEX == CART_INDEX);
  assign accept    = (state == ACTIVE) & IOCTL_WR;
  assign in_word   = {IOCTL_ADDR, IOCTL_DOUT};
  assign h_release = h_valid & h_phase;

  assign byte_addr = h_word.addr + {24'd0, h_phase};
  assign rel_addr  = byte_addr - HDR;
  assign over      = |rel_addr[24:ADDR_W];
  assign cur_byte  = word_byte(h_word, h_phase);

  generate
    if (HDR_BYTES > 0) begin : g_hdr
      assign in_header = byte_addr < HDR;
    end else begin : g_no_hdr
      assign in_header = 1'b0;
    end
  endgenerate

  // Header and oversize bytes still spend their cycle in H, just without a strobe
  assign emit = h_valid & ~in_header & ~over;

  always_comb begin
    state_next   = state;
    h_word_next  = h_word;
    h_valid_next = h_valid;
    h_phase_next = h_phase;
    s_word_next  = s_word;
    s_valid_next = s_valid;

    if (h_valid && !h_phase) begin
      h_phase_next = 1'b1;
    end

    // H frees up on its high byte; S (or a direct strobe) refills it in the same cycle
    if (!h_valid || h_release) begin
      h_phase_next = 1'b0;
      if (s_valid) begin
        h_word_next  = s_word;
        h_valid_next = 1'b1;
        s_valid_next = accept;
        if (accept) begin
          s_word_next = in_word;
        end
      end else if (accept) begin
        h_word_next  = in_word;
        h_valid_next = 1'b1;
      end else begin
        h_valid_next = 1'b0;
      end
    end else if (accept && !s_valid) begin
      s_word_next  = in_word;
      s_valid_next = 1'b1;
    end

    case (state)
      IDLE:    if (sel_match) state_next = ACTIVE;
      ACTIVE:  if (!sel_match) state_next = DRAIN;
      DRAIN:   if (!h_valid_next && !s_valid_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      h_word     <= '0;
      h_valid    <= 1'b0;
      h_phase    <= 1'b0;
      s_word     <= '0;
      s_valid    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      init_sel_q <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      state      <= state_next;
      h_word     <= h_word_next;
      h_valid    <= h_valid_next;
      h_phase    <= h_phase_next;
      s_word     <= s_word_next;
      s_valid    <= s_valid_next;
      init_sel_q <= (state_next != IDLE);
      if (emit) begin
        addr_q <= rel_addr[ADDR_W-1:0];
        data_q <= cur_byte;
      end
      if (state == IDLE && sel_match) begin
        oversize_q <= 1'b0;
      end else if (h_valid && !in_header && over) begin
        oversize_q <= 1'b1;
      end
    end
  end

  assign IOCTL_WAIT = h_valid;
  assign INIT_SEL   = init_sel_q;
  assign INIT_VALID = emit;
  assign INIT_ADDR  = emit ? rel_addr[ADDR_W-1:0] : addr_q;
  assign INIT_DATA  = emit ? cur_byte : data_q;
  assign OVERSIZE   = oversize_q;

endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - scoreboard bench for cart_loader, header 0 and header 3 instances
`timescale 1ns/1ps
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [24:0] addr;
  logic [15:0] dout;

  logic        w0, sel0, v0, ov0;
  logic [16:0] a0;
  logic [7:0]  d0;
  logic        w3, sel3, v3, ov3;
  logic [16:0] a3;
  logic [7:0]  d3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cart_loader #(.CART_INDEX(8'h01), .HDR_BYTES(0), .ADDR_W(17)) dut0 (
    .CLK(clk), .RESET(rst), .IOCTL_DOWNLOAD(dl), .IOCTL_INDEX(idx), .IOCTL_WR(wr),
    .IOCTL_ADDR(addr), .IOCTL_DOUT(dout), .IOCTL_WAIT(w0), .INIT_SEL(sel0),
    .INIT_ADDR(a0), .INIT_DATA(d0), .INIT_VALID(v0), .OVERSIZE(ov0)
  );

  cart_loader #(.CART_INDEX(8'h01), .HDR_BYTES(3), .ADDR_W(17)) dut3 (
    .CLK(clk), .RESET(rst), .IOCTL_DOWNLOAD(dl), .IOCTL_INDEX(idx), .IOCTL_WR(wr),
    .IOCTL_ADDR(addr), .IOCTL_DOUT(dout), .IOCTL_WAIT(w3), .INIT_SEL(sel3),
    .INIT_ADDR(a3), .INIT_DATA(d3), .INIT_VALID(v3), .OVERSIZE(ov3)
  );

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   vcyc0[$];

  int          checks = 0;
  int          errors = 0;
  int          n_v0 = 0;
  int          n_v3 = 0;
  int          max_a0 = 0;
  int          last_v_cyc0 = 0;
  logic [16:0] last_a3 = '0;
  logic [7:0]  last_d3 = '0;
  bit          session = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [24:0] wa, input logic [15:0] wd);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      int b;
      b   = int'(wa) + k;
      e.d = (k == 1) ? wd[15:8] : wd[7:0];
      if (b < 32'h20000) begin
        e.a = b[16:0];
        q0.push_back(e);
      end
      if (b >= 3 && (b - 3) < 32'h20000) begin
        e.a = 17'(b - 3);
        q3.push_back(e);
      end
    end
  endtask

  task automatic send_word(input logic [24:0] wa, input logic [15:0] wd, input bit honor_wait);
    if (honor_wait) begin
      int n;
      n = 0;
      while ((w0 || w3) && n < 20) begin
        tick();
        n++;
      end
      if (w0 || w3) begin
        checks++;
        errors++;
        $display("FAIL wait_timeout actual=1 required=0");
      end
    end
    wr   = 1'b1;
    addr = wa;
    dout = wd;
    if (session) push_exp(wa, wd);
    tick();
    wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] i);
    dl      = 1'b1;
    idx     = i;
    session = (i == 8'h01);
    tick();
    tick();
  endtask

  task automatic end_dl(input string name);
    int n;
    dl      = 1'b0;
    session = 1'b0;
    n       = 0;
    while ((sel0 || sel3) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_sel_fall"}, {30'd0, sel0, sel3}, 32'd0);
    chk({name, "_q0_empty"}, q0.size(), 32'd0);
    chk({name, "_q3_empty"}, q3.size(), 32'd0);
  endtask

  initial begin
    int base0, base3, fall_cyc;

    fork
      forever begin
        @(negedge clk);
        if (v0 === 1'b1) begin
          n_v0++;
          vcyc0.push_back(cyc);
          last_v_cyc0 = cyc;
          if (int'(a0) > max_a0) max_a0 = int'(a0);
          if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0_spurious_byte actual=%h:%h required=none", a0, d0);
          end else begin
            exp_t e;
            e = q0.pop_front();
            chk("dut0_byte", {15'd0, a0, d0}, {15'd0, e.a, e.d});
          end
        end
        if (v3 === 1'b1) begin
          n_v3++;
          last_a3 = a3;
          last_d3 = d3;
          if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut3_spurious_byte actual=%h:%h required=none", a3, d3);
          end else begin
            exp_t e;
            e = q3.pop_front();
            chk("dut3_byte", {15'd0, a3, d3}, {15'd0, e.a, e.d});
          end
        end
      end
    join_none

    rst  = 1'b1;
    dl   = 1'b0;
    idx  = 8'h00;
    wr   = 1'b0;
    addr = '0;
    dout = '0;
    tick();
    tick();
    chk("rst_outputs", {26'd0, sel0, v0, w0, ov0, sel3, v3}, 32'd0);
    chk("rst_addr_data", {7'd0, a0, d0}, 32'd0);
    rst = 1'b0;
    tick();

    // 8 KiB image, no header
    n_v0   = 0;
    max_a0 = 0;
    start_dl(8'h01);
    chk("sel_rise", {31'd0, sel0}, 32'd1);
    for (int w = 0; w < 4096; w++) send_word(25'(w * 2), 16'h2211, 1'b1);
    end_dl("img8k");
    chk("img8k_count", n_v0, 32'd8192);
    chk("img8k_log2", $clog2(max_a0 + 1), 32'd13);

    // back-to-back strobes, second one ignores WAIT
    start_dl(8'h01);
    vcyc0.delete();
    send_word(25'h0, 16'h3412, 1'b1);
    send_word(25'h2, 16'h7856, 1'b0);
    end_dl("b2b");
    chk("b2b_count", vcyc0.size(), 32'd4);
    if (vcyc0.size() == 4) chk("b2b_span", vcyc0[3] - vcyc0[0], 32'd3);

    // header stripping on the HDR_BYTES=3 instance
    start_dl(8'h01);
    base3 = n_v3;
    send_word(25'h0, 16'hBBAA, 1'b1);
    send_word(25'h2, 16'hDDCC, 1'b1);
    end_dl("hdr");
    chk("hdr_count", n_v3 - base3, 32'd1);
    chk("hdr_addr", {15'd0, last_a3}, 32'd0);
    chk("hdr_data", {24'd0, last_d3}, 32'hDD);

    // image running past 128 KiB
    start_dl(8'h01);
    chk("ov_initial", {30'd0, ov0, ov3}, 32'd0);
    send_word(25'h1FFFC, 16'h4433, 1'b1);
    send_word(25'h1FFFE, 16'h6655, 1'b1);
    send_word(25'h20000, 16'h8877, 1'b1);
    send_word(25'h20002, 16'hAA99, 1'b1);
    end_dl("ov");
    chk("ov_set", {30'd0, ov0, ov3}, 32'd3);

    // foreign index: nothing moves
    base0 = n_v0;
    start_dl(8'h00);
    send_word(25'h0, 16'h5555, 1'b1);
    send_word(25'h2, 16'h6666, 1'b1);
    chk("foreign_sel", {30'd0, sel0, sel3}, 32'd0);
    end_dl("foreign");
    chk("foreign_ov_kept", {30'd0, ov0, ov3}, 32'd3);
    chk("foreign_no_bytes", n_v0 - base0, 32'd0);

    // new cartridge session clears OVERSIZE; last word lands as DOWNLOAD falls
    start_dl(8'h01);
    chk("ov_cleared", {30'd0, ov0, ov3}, 32'd0);
    send_word(25'h0, 16'h0FF0, 1'b1);
    begin
      int n;
      n = 0;
      while ((w0 || w3) && n < 20) begin
        tick();
        n++;
      end
    end
    dl = 1'b0;
    send_word(25'h2, 16'hF00F, 1'b0);
    session  = 1'b0;
    fall_cyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!sel0) begin
        fall_cyc = cyc;
        break;
      end
    end
    chk("drop_sel_fall_cycle", fall_cyc, last_v_cyc0 + 1);
    tick();
    chk("drop_q0_empty", q0.size(), 32'd0);
    chk("drop_q3_empty", q3.size(), 32'd0);

    // asynchronous reset while H holds a word
    start_dl(8'h01);
    send_word(25'h0, 16'h2B1A, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_dut0", {29'd0, sel0, v0, w0}, 32'd0);
    chk("rst_mid_dut3", {29'd0, sel3, v3, w3}, 32'd0);
    q0.delete();
    q3.delete();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base0 = n_v0;
    tick();
    tick();
    chk("rst_restart_sel", {31'd0, sel0}, 32'd1);
    send_word(25'h0, 16'h4C3D, 1'b1);
    end_dl("restart");
    chk("restart_count", n_v0 - base0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Upstream feeder for the cartridge ROM store. Converts the host download stream (16-bit words, byte-addressed, one-cycle write strobes) into the ROM store's byte-wide init interface: INIT_SEL, INIT_ADDR, INIT_DATA, INIT_VALID.
- Also strips an optional file header, flags oversize images, and drains all buffered bytes before dropping INIT_SEL. This lets the ROM store latch its final size/checksum on the falling edge of INIT_SEL.

Parameters:
- CART_INDEX, 8'h01: download index that selects the cartridge image.
- HDR_BYTES, 0: count of leading file bytes discarded before ROM byte 0.
- ADDR_W, 17: ROM byte address width (128 KiB).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset. Asynchronous, active-high.
- IOCTL_DOWNLOAD  in  1  host download in progress.
- IOCTL_INDEX  in  8  image index of the current download.
- IOCTL_WR  in  1  one-cycle strobe; IOCTL_ADDR/IOCTL_DOUT valid.
- IOCTL_ADDR  in  25  file byte address of the word (always even).
- IOCTL_DOUT  in  16  data word; [7:0] = byte at ADDR, [15:8] = byte at ADDR+1.
- IOCTL_WAIT  out  1  host must not issue a new strobe while high.
- INIT_SEL  out  1  to ROM store: load session active.
- INIT_ADDR  out  ADDR_W  to ROM store: byte address.
- INIT_DATA  out  8  to ROM store: byte data.
- INIT_VALID  out  1  to ROM store: one byte written this cycle.
- OVERSIZE  out  1  sticky: image exceeded 2^ADDR_W bytes after the header.

Behaviour:
- Reset values: all outputs 0; state IDLE; both word registers empty.
- sel_match = IOCTL_DOWNLOAD & (IOCTL_INDEX == CART_INDEX).
- States:
  - IDLE: on sel_match go to ACTIVE. INIT_SEL rises the next cycle. OVERSIZE clears in the same cycle.
  - ACTIVE: accept words. When sel_match drops, go to DRAIN.
  - DRAIN: continue emitting buffered bytes. When both registers are empty, go to IDLE; INIT_SEL falls that cycle.
  - IOCTL_WR is ignored in IDLE and DRAIN.
- INIT_SEL is registered and is 1 in ACTIVE and DRAIN only.
- Buffering: holding register H (word + address) and skid register S.
  - A strobe loads H if H is empty, otherwise S.
  - A strobe while both are full is a protocol violation: the word is dropped.
- IOCTL_WAIT is registered and is 1 whenever H is full. One cycle of host reaction latency is therefore absorbed by S.
- Emission: at most one byte per cycle, from H, low byte then high byte.
  - Strobe at cycle N with H empty: low byte has INIT_VALID at N+1; high byte at N+2.
  - H refills from S in the same cycle its high byte is emitted.
- Byte address: b = IOCTL_ADDR + k, where k = 0 for the low byte and 1 for the high byte.
  - If b < HDR_BYTES: the byte is consumed silently (INIT_VALID = 0) and still takes its cycle.
  - Otherwise r = b - HDR_BYTES, computed 25 bits wide.
  - If r >= 2^ADDR_W: no INIT_VALID, and OVERSIZE is set.
  - Otherwise INIT_ADDR = r[ADDR_W-1:0], INIT_DATA = the byte, INIT_VALID = 1.
- INIT_ADDR and INIT_DATA hold their last value when INIT_VALID = 0.
- IOCTL_DOWNLOAD falling on the same cycle as a strobe: the word is accepted, then the state moves to DRAIN.
- A new sel_match while in DRAIN is ignored until IDLE is reached; the host guarantees a gap between downloads.
- Downloads with another index leave all outputs untouched.
- RESET asserted mid-session: buffers cleared, INIT_SEL = 0 immediately (asynchronous), no further INIT_VALID. The ROM store's contents are then undefined.

Decomposition:
- Shared package scv_pkg:
  - CART_ADDR_W = 17
  - CART_IDX = 8'h01
  - typedef cart_word_t {logic [24:0] addr; logic [15:0] data;}
- No sub-module. H/S and the 3-state FSM stay inline (about 150 lines). The FSM state enum is local.

Test Plan:
- 8 KiB image, HDR_BYTES=0, words 0x2211 at addr 0 through addr 0x1FFE -> 8192 INIT_VALID pulses at INIT_ADDR 0..0x1FFF, byte 0 = 0x11, byte 1 = 0x22. INIT_SEL falls after the final byte, and the ROM store reports size log2 = 13.
- Back-to-back strobes on consecutive cycles (WAIT ignored for 1 cycle) -> S absorbs the second word; 4 bytes emitted on 4 consecutive cycles in order; no loss.
- HDR_BYTES=3, first words 0xBBAA@0 and 0xDDCC@2 -> AA, BB, CC dropped; DD emitted at INIT_ADDR 0.
- 128 KiB + 2 bytes -> last word produces no INIT_VALID; OVERSIZE = 1; OVERSIZE clears on the next cartridge download start.
- Strobe on the same cycle IOCTL_DOWNLOAD falls -> both bytes emitted in DRAIN; INIT_SEL falls the cycle after the high byte; a download with index 0x00 produces no activity.
- RESET pulsed while H is full -> INIT_SEL, INIT_VALID and IOCTL_WAIT are 0 in the same cycle; the next download starts cleanly from INIT_ADDR 0.
